microwave_time_entry: RTL and testbench

- Keypad-side writer for the microwave timer counter chain. It drives the BCD digit inputs and the load strobe that the mod-6/mod-10 down-counters consume.
- Accepts decimal key strobes, shifts them into a 3-digit M:SS entry register and validates the entry on start.
- Issues a one-cycle load pulse, then tracks the countdown until the chain reports zero or the user cancels.

---
 rtl/microwave_time_entry.sv | 163 ++++++++++++++++
 tb/tb_microwave_time_entry.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/microwave_time_entry.sv
// Keypad entry front-end for the microwave M:SS down-counter chain: shifts digits, validates, loads, tracks run.
// Optional quick start (0:30 default from empty IDLE, restart from RUN) enabled by `define MICROWAVE_QUICK_START_EN.
module microwave_time_entry #(
    parameter int MAX_SEC_TENS   = 5,
    parameter int MAX_DIGITS     = 3,
    parameter int QUICK_SEC_TENS = 3
) (
    input  logic       clk,
    input  logic       clear_n,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       start,
    input  logic       cancel,
    input  logic       timer_zero,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       load,
    output logic       running,
    output logic [1:0] digit_count,
    output logic       err,
    output logic       done
);

    // state | meaning
    // IDLE  | no entry in progress, digits cleared
    // ENTRY | collecting digits, waiting for start
    // LOAD  | one-cycle load strobe to the counter chain
    // RUN   | countdown in progress, waiting for timer_zero
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        LOAD  = 2'd2,
        RUN   = 2'd3
    } state_t;

    localparam logic [1:0] MAX_CNT    = 2'(MAX_DIGITS);
    localparam logic [3:0] TENS_LIMIT = 4'(MAX_SEC_TENS);

    state_t     state, state_nx;
    logic [3:0] min_nx, tens_nx, ones_nx;
    logic [1:0] cnt_nx;
    logic       err_nx, done_nx;
    logic       run_first;
    logic       key_legal, key_bad;

    assign key_legal = key_valid && (key_code <= 4'd9);
    assign key_bad   = key_valid && (key_code > 4'd9);

    always_comb begin
        state_nx = state;
        min_nx   = min_ones;
        tens_nx  = sec_tens;
        ones_nx  = sec_ones;
        cnt_nx   = digit_count;
        err_nx   = 1'b0;
        done_nx  = 1'b0;

        unique case (state)
            IDLE: begin
                if (cancel) begin
                    min_nx  = 4'd0;
                    tens_nx = 4'd0;
                    ones_nx = 4'd0;
                    cnt_nx  = 2'd0;
                end else if (start) begin
`ifdef MICROWAVE_QUICK_START_EN
                    if (digit_count == 2'd0) begin
                        min_nx   = 4'd0;
                        tens_nx  = 4'(QUICK_SEC_TENS);
                        ones_nx  = 4'd0;
                        state_nx = LOAD;
                    end
`endif
                end else if (key_legal) begin
                    min_nx   = sec_tens;
                    tens_nx  = sec_ones;
                    ones_nx  = key_code;
                    cnt_nx   = digit_count + 2'd1;
                    state_nx = ENTRY;
                end else if (key_bad) begin
                    err_nx = 1'b1;
                end
            end
            ENTRY: begin
                if (cancel) begin
                    min_nx   = 4'd0;
                    tens_nx  = 4'd0;
                    ones_nx  = 4'd0;
                    cnt_nx   = 2'd0;
                    state_nx = IDLE;
                end else if (start) begin
                    if ((sec_tens > TENS_LIMIT) ||
                        (min_ones == 4'd0 && sec_tens == 4'd0 && sec_ones == 4'd0))
                        err_nx = 1'b1;
                    else
                        state_nx = LOAD;
                end else if (key_bad) begin
                    err_nx = 1'b1;
                end else if (key_legal && digit_count < MAX_CNT) begin
                    min_nx  = sec_tens;
                    tens_nx = sec_ones;
                    ones_nx = key_code;
                    cnt_nx  = digit_count + 2'd1;
                end
            end
            LOAD: begin
                if (cancel) begin
                    min_nx   = 4'd0;
                    tens_nx  = 4'd0;
                    ones_nx  = 4'd0;
                    cnt_nx   = 2'd0;
                    state_nx = IDLE;
                end else begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                // the counters may still report a stale zero until the load lands
                if (cancel || (timer_zero && !run_first)) begin
                    min_nx   = 4'd0;
                    tens_nx  = 4'd0;
                    ones_nx  = 4'd0;
                    cnt_nx   = 2'd0;
                    done_nx  = !cancel;
                    state_nx = IDLE;
                end else if (start) begin
`ifdef MICROWAVE_QUICK_START_EN
                    state_nx = LOAD;
`endif
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state       <= IDLE;
            min_ones    <= 4'd0;
            sec_tens    <= 4'd0;
            sec_ones    <= 4'd0;
            digit_count <= 2'd0;
            load        <= 1'b0;
            running     <= 1'b0;
            err         <= 1'b0;
            done        <= 1'b0;
            run_first   <= 1'b0;
        end else begin
            state       <= state_nx;
            min_ones    <= min_nx;
            sec_tens    <= tens_nx;
            sec_ones    <= ones_nx;
            digit_count <= cnt_nx;
            load        <= (state_nx == LOAD);
            running     <= (state_nx == RUN);
            err         <= err_nx;
            done        <= done_nx;
            run_first   <= (state == LOAD) && (state_nx == RUN);
        end
    end

endmodule

// File: tb/tb_microwave_time_entry.sv
// Bench for microwave_time_entry: directed test-plan steps plus random traffic checked against an entry-value model.
// Model follows `define MICROWAVE_QUICK_START_EN when the design is built with it.
module tb_microwave_time_entry;

    logic       clk = 1'b0;
    logic       clear_n;
    logic       key_valid;
    logic [3:0] key_code;
    logic       start;
    logic       cancel;
    logic       timer_zero;
    logic [3:0] min_ones, sec_tens, sec_ones;
    logic       load, running, err, done;
    logic [1:0] digit_count;

    int tests = 0;
    int fails = 0;

    localparam int P_IDLE = 0, P_ENTRY = 1, P_LOAD = 2, P_RUN = 3;

    // model: the entry is just a decimal number built from accepted keys
    int m_phase, m_val, m_cnt, m_age;
    logic e_err, e_done;

    microwave_time_entry dut (
        .clk         (clk),
        .clear_n     (clear_n),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .start       (start),
        .cancel      (cancel),
        .timer_zero  (timer_zero),
        .min_ones    (min_ones),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .load        (load),
        .running     (running),
        .digit_count (digit_count),
        .err         (err),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_val = 0; m_cnt = 0; m_age = 0;
        e_err = 1'b0; e_done = 1'b0;
    endtask

    task automatic model_clear();
        m_phase = P_IDLE; m_val = 0; m_cnt = 0;
    endtask

    task automatic model_step(input logic kv, input int kc, input logic st, input logic cn, input logic tz);
        e_err = 1'b0; e_done = 1'b0;
        if (m_phase == P_IDLE || m_phase == P_ENTRY) begin
            if (cn) model_clear();
            else if (st) begin
                if (m_phase == P_ENTRY) begin
                    if (m_val == 0 || (m_val / 10) % 10 > 5) e_err = 1'b1;
                    else m_phase = P_LOAD;
                end
`ifdef MICROWAVE_QUICK_START_EN
                else if (m_cnt == 0) begin
                    m_val = 30; m_phase = P_LOAD;
                end
`endif
            end else if (kv) begin
                if (kc > 9) e_err = 1'b1;
                else if (m_cnt < 3) begin
                    m_val = m_val * 10 + kc; m_cnt++; m_phase = P_ENTRY;
                end
            end
        end else if (m_phase == P_LOAD) begin
            if (cn) model_clear();
            else begin m_phase = P_RUN; m_age = 0; end
        end else begin
            if (cn) model_clear();
            else if (tz && m_age > 0) begin model_clear(); e_done = 1'b1; end
`ifdef MICROWAVE_QUICK_START_EN
            else if (st) m_phase = P_LOAD;
`endif
            else m_age++;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".min"},  min_ones, 4'(m_val / 100));
        check({tag, ".tens"}, sec_tens, 4'((m_val / 10) % 10));
        check({tag, ".ones"}, sec_ones, 4'(m_val % 10));
        check({tag, ".cnt"},  {2'b00, digit_count}, 4'(m_cnt));
        check({tag, ".load"}, {3'b000, load},    {3'b000, m_phase == P_LOAD});
        check({tag, ".run"},  {3'b000, running}, {3'b000, m_phase == P_RUN});
        check({tag, ".err"},  {3'b000, err},  {3'b000, e_err});
        check({tag, ".done"}, {3'b000, done}, {3'b000, e_done});
    endtask

    task automatic cycle(input string tag, input logic kv, input logic [3:0] kc,
                         input logic st, input logic cn, input logic tz);
        key_valid = kv; key_code = kc; start = st; cancel = cn; timer_zero = tz;
        model_step(kv, int'(kc), st, cn, tz);
        @(posedge clk); #1;
        check_all(tag);
    endtask

    task automatic key(input string tag, input logic [3:0] kc);
        cycle(tag, 1'b1, kc, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        clear_n = 1'b0; key_valid = 1'b0; key_code = 4'd0;
        start = 1'b0; cancel = 1'b0; timer_zero = 1'b0;
        model_reset();
        @(posedge clk); #1;
        check_all("reset");
        clear_n = 1'b1;

        // 5:30 entry and load
        key("k5", 4'd5);
        check("k5.ones_abs", sec_ones, 4'd5);
        key("k3", 4'd3);
        key("k0", 4'd0);
        check("530.min_abs", min_ones, 4'd5);
        check("530.cnt_abs", {2'b00, digit_count}, 4'd3);
        cycle("start530", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        check("start530.load_abs", {3'b000, load}, 4'd1);
        cycle("run530", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        check("run530.load_abs", {3'b000, load}, 4'd0);
        check("run530.run_abs", {3'b000, running}, 4'd1);
        key("run_key", 4'd7);
        cycle("cancel_run", 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);

        // 1:75 rejected
        key("k1", 4'd1); key("k7", 4'd7); key("k5b", 4'd5);
        cycle("start175", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        check("start175.err_abs", {3'b000, err}, 4'd1);
        check("start175.tens_abs", sec_tens, 4'd7);
        cycle("cancel175", 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);

        // overflow key and illegal key
        key("k2", 4'd2); key("k0a", 4'd0); key("k0b", 4'd0);
        key("k9_ignored", 4'd9);
        check("k9.err_abs", {3'b000, err}, 4'd0);
        key("k12", 4'd12);
        check("k12.err_abs", {3'b000, err}, 4'd1);
        check("k12.min_abs", min_ones, 4'd2);
        cycle("cancel200", 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);

        // 0:10 with timer_zero held from the first RUN cycle
        key("k0c", 4'd0); key("k1b", 4'd1); key("k0d", 4'd0);
        cycle("start010", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        cycle("load010", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        cycle("run1_tz", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        check("run1_tz.done_abs", {3'b000, done}, 4'd0);
        cycle("run2_tz", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        check("run2_tz.done_abs", {3'b000, done}, 4'd1);
        check("run2_tz.ones_abs", sec_ones, 4'd0);

        // start on all-zero entry, then cancel+start together
        key("z0", 4'd0);
        cycle("start_zero", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        check("start_zero.err_abs", {3'b000, err}, 4'd1);
        cycle("cancel_zero", 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        key("k1c", 4'd1); key("k0e", 4'd0); key("k0f", 4'd0);
        cycle("cancel_start", 1'b1, 4'd4, 1'b1, 1'b1, 1'b0);
        check("cancel_start.load_abs", {3'b000, load}, 4'd0);
        check("cancel_start.cnt_abs", {2'b00, digit_count}, 4'd0);

        // start from empty IDLE (quick start only when enabled)
        cycle("idle_start", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        cycle("idle_after", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        cycle("cancel_q", 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);

        // reset dropped in LOAD
        key("k1d", 4'd1); key("k2b", 4'd2);
        cycle("start12", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        check("start12.load_abs", {3'b000, load}, 4'd1);
        #3 clear_n = 1'b0;
        #1 model_reset();
        check_all("async_rst");
        check("async_rst.load_abs", {3'b000, load}, 4'd0);
        #1 clear_n = 1'b1;
        cycle("post_rst", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic kv, st, cn, tz;
            logic [3:0] kc;
            kv = ($urandom_range(0, 9) < 4);
            kc = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            st = ($urandom_range(0, 19) < 2);
            cn = ($urandom_range(0, 59) == 0);
            tz = (m_phase == P_RUN) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 19) == 0);
            cycle("rand", kv, kc, st, cn, tz);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
